// File: rtl/apb_fabric_n.sv
// APB interconnect: one bridge master fanned out to NUM_SLV slaves with BASE/MASK decode,
// default-slave error for unmapped addresses, ACCESS-phase timeout and first-error capture.

module apb_fabric_n_dec #(
    parameter int              AW   = 32,
    parameter logic [AW-1:0]   BASE = '0,
    parameter logic [AW-1:0]   MASK = '0
) (
    input  logic [AW-1:0] paddr,
    output logic          hit
);
    assign hit = ((paddr & MASK) == BASE);
endmodule

module apb_fabric_n #(
    parameter int                     NUM_SLV     = 4,
    parameter int                     AW          = 32,
    parameter int                     DW          = 32,
    parameter logic [NUM_SLV*AW-1:0]  SLV_BASE    = {4{32'h0}},
    parameter logic [NUM_SLV*AW-1:0]  SLV_MASK    = {4{32'hF000_0000}},
    parameter int                     TIMEOUT_CYC = 255,
    parameter int                     TO_W        = 8
) (
    input  logic                   PCLK,
    input  logic                   rst,
    input  logic                   PSEL,
    input  logic [AW-1:0]          PADDR,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [DW-1:0]          PWDATA,
    input  logic [DW/8-1:0]        PSTRB,
    output logic [DW-1:0]          PRDATA,
    output logic                   PREADY,
    output logic                   PSLVERR,
    output logic [NUM_SLV-1:0]     s_psel,
    output logic                   s_penable,
    output logic [AW-1:0]          s_paddr,
    output logic                   s_pwrite,
    output logic [DW-1:0]          s_pwdata,
    output logic [DW/8-1:0]        s_pstrb,
    input  logic [NUM_SLV*DW-1:0]  s_prdata,
    input  logic [NUM_SLV-1:0]     s_pready,
    input  logic [NUM_SLV-1:0]     s_pslverr,
    input  logic                   err_clr,
    output logic                   err_valid,
    output logic [AW-1:0]          err_addr,
    output logic [1:0]             err_code,
    output logic                   err_write
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam bit              TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] CODE_UNMAP = 2'b01;
    localparam logic [1:0] CODE_TO    = 2'b10;
    localparam logic [1:0] CODE_SLV   = 2'b11;

    logic [1:0]         state_q, state_d, phase;
    logic [NUM_SLV-1:0] hit, dec_oh, sel_q;
    logic               miss, miss_q;
    logic [TO_W-1:0]    to_cnt;
    logic               access, slv_rdy, slv_err, to_fire, err_ev;
    logic [DW-1:0]      slv_rdata;
    logic [1:0]         ev_code;

    assign s_paddr  = PADDR;
    assign s_pwrite = PWRITE;
    assign s_pwdata = PWDATA;
    assign s_pstrb  = PSTRB;

    for (genvar i = 0; i < NUM_SLV; i++) begin : g_dec
        apb_fabric_n_dec #(
            .AW  (AW),
            .BASE(SLV_BASE[i*AW +: AW]),
            .MASK(SLV_MASK[i*AW +: AW])
        ) u_dec (
            .paddr(PADDR),
            .hit  (hit[i])
        );
    end

    // Lowest index wins on overlapping windows.
    always_comb begin
        dec_oh = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (hit[i]) dec_oh = NUM_SLV'(1) << i;
        end
    end
    assign miss = ~|hit;

    // SETUP is resolved from the live master inputs so the slave sees its select during
    // the master's setup cycle; only ACCESS is held in the state register.
    always_comb begin
        phase = ST_IDLE;
        if (rst)                        phase = ST_IDLE;
        else if (state_q == ST_ACCESS)  phase = ST_ACCESS;
        else if (PSEL && !PENABLE)      phase = ST_SETUP;
    end

    assign access = (phase == ST_ACCESS) && PSEL;

    always_comb begin
        slv_rdy   = 1'b0;
        slv_err   = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            slv_rdy   = slv_rdy   | (sel_q[i] & s_pready[i]);
            slv_err   = slv_err   | (sel_q[i] & s_pslverr[i]);
            slv_rdata = slv_rdata | (s_prdata[i*DW +: DW] & {DW{sel_q[i]}});
        end
    end

    // A slave ready in the expiry cycle takes precedence over the timeout.
    assign to_fire = access && !miss_q && TO_EN && !slv_rdy && (to_cnt == TO_LAST);

    always_comb begin
        s_psel    = '0;
        s_penable = 1'b0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = '0;
        if (phase == ST_SETUP) begin
            s_psel = dec_oh;
        end else if (access) begin
            if (miss_q || to_fire) begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
            end else begin
                s_psel    = sel_q;
                s_penable = PENABLE;
                PREADY    = slv_rdy;
                PSLVERR   = slv_err;
                PRDATA    = slv_rdata;
            end
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (phase)
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: state_d = (PSEL && !PREADY) ? ST_ACCESS : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            miss_q  <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (phase == ST_SETUP) begin
                sel_q  <= dec_oh;
                miss_q <= miss;
                to_cnt <= '0;
            end else if (access && !miss_q && !slv_rdy && TO_EN) begin
                to_cnt <= to_cnt + TO_ONE;
            end
        end
    end

    assign err_ev  = access && PREADY && PSLVERR;
    assign ev_code = miss_q ? CODE_UNMAP : (to_fire ? CODE_TO : CODE_SLV);

    // A clear coincident with a new error still captures that error.
    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_code  <= 2'b00;
            err_write <= 1'b0;
        end else if (err_ev && (!err_valid || err_clr)) begin
            err_valid <= 1'b1;
            err_addr  <= PADDR;
            err_code  <= ev_code;
            err_write <= PWRITE;
        end else if (err_clr) begin
            err_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_apb_fabric_n.sv
// Randomized bench for apb_fabric_n: a transaction-level model predicts slave choice,
// completion cycle, response and error capture from the address map and slave wait counts.

module tb_apb_fabric_n;
    localparam int NS  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TOC = 4;

    localparam logic [31:0] BASE_A [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h4000_0000};
    localparam logic [31:0] MASK_A [NS] = '{32'hE000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

    logic             PCLK, rst, PSEL, PENABLE, PWRITE;
    logic [AW-1:0]    PADDR;
    logic [DW-1:0]    PWDATA, PRDATA;
    logic [DW/8-1:0]  PSTRB, s_pstrb;
    logic             PREADY, PSLVERR;
    logic [NS-1:0]    s_psel, s_pready, s_pslverr;
    logic             s_penable, s_pwrite;
    logic [AW-1:0]    s_paddr;
    logic [DW-1:0]    s_pwdata;
    logic [NS*DW-1:0] s_prdata;
    logic             err_clr, err_valid, err_write;
    logic [AW-1:0]    err_addr;
    logic [1:0]       err_code;

    apb_fabric_n #(
        .NUM_SLV(NS), .AW(AW), .DW(DW),
        .SLV_BASE({BASE_A[3], BASE_A[2], BASE_A[1], BASE_A[0]}),
        .SLV_MASK({MASK_A[3], MASK_A[2], MASK_A[1], MASK_A[0]}),
        .TIMEOUT_CYC(TOC), .TO_W(3)
    ) dut (
        .PCLK(PCLK), .rst(rst), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .s_psel(s_psel), .s_penable(s_penable),
        .s_paddr(s_paddr), .s_pwrite(s_pwrite), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .err_clr(err_clr), .err_valid(err_valid), .err_addr(err_addr),
        .err_code(err_code), .err_write(err_write)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave stubs: ready once they have been in ACCESS for waits[i] cycles.
    int          waits [NS];
    logic        serr  [NS];
    logic [31:0] sdata [NS];
    int          cnt   [NS];

    always @(posedge PCLK or posedge rst) begin
        for (int i = 0; i < NS; i++) begin
            if (rst) cnt[i] <= 0;
            else     cnt[i] <= (s_psel[i] && s_penable) ? cnt[i] + 1 : 0;
        end
    end

    always_comb begin
        s_pready  = '0;
        s_pslverr = '0;
        s_prdata  = '0;
        for (int i = 0; i < NS; i++) begin
            s_pready[i]          = (cnt[i] == waits[i]);
            s_pslverr[i]         = serr[i];
            s_prdata[i*32 +: 32] = sdata[i];
        end
    end

    int          n_cmp, n_mis;
    logic        m_valid, m_write;
    logic [31:0] m_addr;
    logic [1:0]  m_code;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int target(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & MASK_A[i]) == BASE_A[i]) return i;
        return -1;
    endfunction

    task automatic chk_err();
        chk("err_valid", 32'(err_valid), 32'(m_valid));
        if (m_valid) begin
            chk("err_addr", err_addr, m_addr);
            chk("err_code", 32'(err_code), 32'(m_code));
            chk("err_write", 32'(err_write), 32'(m_write));
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic w, input logic clr,
                        input logic mid, input logic [31:0] a_mid);
        int t, ec, k;
        logic e_err, to, rdy;
        logic [31:0] e_rd;
        logic [1:0] e_code;
        logic [3:0] oh;
        t  = target(a);
        oh = (t < 0) ? 4'b0 : 4'(1 << t);
        if (t < 0) begin
            ec = 1; e_err = 1'b1; e_rd = 0; e_code = 2'b01; to = 1'b0;
        end else if (waits[t] + 1 > TOC) begin
            ec = TOC; e_err = 1'b1; e_rd = 0; e_code = 2'b10; to = 1'b1;
        end else begin
            ec = waits[t] + 1; e_err = serr[t]; e_rd = sdata[t]; e_code = 2'b11; to = 1'b0;
        end
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w;
        PWDATA = $urandom; PSTRB = 4'($urandom); err_clr = 1'b0;
        @(negedge PCLK);
        chk("setup_psel", 32'(s_psel), 32'(oh));
        chk("s_paddr", s_paddr, a);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        if (mid) PADDR = a_mid;
        k = 1;
        forever begin
            err_clr = clr && (k == ec);
            @(negedge PCLK);
            rdy = PREADY;
            chk("acc_psel", 32'(s_psel), 32'((t < 0 || (to && k == ec)) ? 4'b0 : oh));
            if (t >= 0) chk("acc_penable", 32'(s_penable), 32'(!(to && k == ec)));
            chk("acc_pready", 32'(rdy), 32'(k == ec));
            if (rdy) begin
                chk("prdata", PRDATA, e_rd);
                chk("pslverr", 32'(PSLVERR), 32'(e_err));
            end
            @(posedge PCLK);
            if (rdy && e_err && (err_clr || !m_valid)) begin
                m_valid = 1'b1; m_addr = a; m_code = e_code; m_write = w;
            end else if (err_clr) begin
                m_valid = 1'b0;
            end
            #1;
            err_clr = 1'b0;
            if (rdy) break;
            k++;
            if (k > 12) begin
                chk("xfer_bound", 32'd0, 32'd1);
                break;
            end
        end
        chk_err();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge PCLK); #1;
        err_clr = 1'b0;
        m_valid = 1'b0;
        chk("clr_valid", 32'(err_valid), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge PCLK); #1;
        end
    endtask

    task automatic start_hung(input logic [31:0] a);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        n_cmp = 0; n_mis = 0;
        m_valid = 1'b0; m_write = 1'b0; m_addr = 0; m_code = 0;
        rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PADDR = 0; PWRITE = 1'b0;
        PWDATA = 0; PSTRB = 0; err_clr = 1'b0;
        for (int i = 0; i < NS; i++) begin
            waits[i] = 0; serr[i] = 1'b0; sdata[i] = 32'hA000_0000 + i;
        end
        idle(3);
        chk("rst_pready", 32'(PREADY), 32'd0);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_psel", 32'(s_psel), 32'd0);
        chk_err();
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        rst = 1'b0;
        idle(1);

        // slave 2, three waits: completes on ACCESS cycle 4, which is also the timeout boundary
        waits[2] = 3; sdata[2] = 32'h2222_5555;
        xfer(32'h2000_0010, 1'b1, 1'b0, 1'b0, 0);
        xfer(32'h7000_0000, 1'b0, 1'b0, 1'b0, 0);
        pulse_clr();
        waits[2] = 1000;
        xfer(32'h2000_0100, 1'b1, 1'b0, 1'b0, 0);
        pulse_clr();

        // two errors back-to-back, then a clear coincident with a third
        waits[3] = 1; serr[3] = 1'b1;
        xfer(32'h9000_0000, 1'b0, 1'b0, 1'b0, 0);
        xfer(32'h4000_0040, 1'b1, 1'b0, 1'b0, 0);
        xfer(32'hA000_0004, 1'b1, 1'b1, 1'b0, 0);
        chk("third_err_addr", err_addr, 32'hA000_0004);
        serr[3] = 1'b0;

        // overlap: 0x1... hits slaves 0 and 1; PADDR moves mid-ACCESS
        waits[0] = 2; sdata[0] = 32'h0000_CAFE; sdata[1] = 32'h1111_BEEF;
        xfer(32'h1000_0008, 1'b0, 1'b0, 1'b1, 32'h2000_0000);
        idle(1);

        // PSEL dropped mid-ACCESS: nothing completes, nothing logged
        waits[2] = 1000;
        start_hung(32'h2000_0000);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        chk("drop_pready", 32'(PREADY), 32'd0);
        chk("drop_psel", 32'(s_psel), 32'd0);
        idle(1);
        chk_err();
        waits[2] = 0;
        xfer(32'h2000_0004, 1'b0, 1'b0, 1'b0, 0);

        // asynchronous reset in the middle of a transfer
        waits[2] = 1000;
        start_hung(32'h2000_0020);
        #1 rst = 1'b1;
        #1;
        chk("mrst_psel", 32'(s_psel), 32'd0);
        chk("mrst_pready", 32'(PREADY), 32'd0);
        chk("mrst_err_valid", 32'(err_valid), 32'd0);
        m_valid = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0;
        idle(1);
        rst = 1'b0;
        idle(1);

        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < NS; i++) begin
                waits[i] = ($urandom_range(0, 5) == 0) ? 1000 : int'($urandom_range(0, 5));
                serr[i]  = ($urandom_range(0, 3) == 0);
                sdata[i] = $urandom;
            end
            a = $urandom;
            case ($urandom_range(0, 4))
                0: a[31:28] = 4'h0;
                1: a[31:28] = 4'h1;
                2: a[31:28] = 4'h2;
                3: a[31:28] = 4'h4;
                default: a[31:28] = 4'($urandom_range(5, 15));
            endcase
            xfer(a, 1'($urandom), ($urandom_range(0, 4) == 0), 1'b0, 0);
            idle(int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
